io_bus_arbiter: RTL and testbench

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

---
 rtl/io_bus_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter that lets two masters (CPU = m0,
// DMA = m1) share one IO bus with RAM, BOARD and SIE regions, each with
// its own wait-state count. The SIE region also waits for sie_rdy.
// Optional macro IO_TIMEOUT_EN adds a WAIT-state watchdog that ends a
// stalled access with a bus error after TIMEOUT cycles.
module io_bus_arbiter #(
  parameter int unsigned RAM_WS   = 0,
  parameter int unsigned BOARD_WS = 1,
  parameter int unsigned SIE_WS   = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_rdy,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_rdy,
  output logic        m1_err,
  output logic [15:0] rdata,
  output logic        ram_sel,
  output logic        board_sel,
  output logic        sie_sel,
  output logic [11:0] io_addr,
  output logic        io_we,
  output logic [15:0] io_wdata,
  input  logic [15:0] ram_rdata,
  input  logic [15:0] board_rdata,
  input  logic [15:0] sie_rdata,
  input  logic        sie_rdy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {R_RAM, R_BOARD, R_SIE, R_NONE} region_t;

  state_t      state_q, state_d;
  region_t     region_q, region_d;
  logic        grant_q, grant_d;
  logic        lastGrant_q, lastGrant_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ramSel_q, ramSel_d;
  logic        boardSel_q, boardSel_d;
  logic        sieSel_q, sieSel_d;
  logic        ioWe_q, ioWe_d;
  logic        rdy0_q, rdy0_d;
  logic        rdy1_q, rdy1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;

  logic        pick;
  logic [15:0] pickAddr;
  logic        waitDone;
  logic [15:0] slaveData;
  logic        finish;
  logic        finishErr;

`ifdef IO_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] toCnt_q, toCnt_d;
`endif

  // A TIMEOUT outside 1..255 cannot be represented by the watchdog counter.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : gTimeoutOutOfRange
  end

  function automatic region_t decodeRegion(input logic [3:0] nib);
    case (nib)
      4'h2:    decodeRegion = R_RAM;
      4'h5:    decodeRegion = R_BOARD;
      4'h6:    decodeRegion = R_SIE;
      default: decodeRegion = R_NONE;
    endcase
  endfunction

  function automatic logic [3:0] regionWs(input region_t r);
    case (r)
      R_RAM:   regionWs = 4'(RAM_WS);
      R_BOARD: regionWs = 4'(BOARD_WS);
      R_SIE:   regionWs = 4'(SIE_WS);
      default: regionWs = 4'd0;
    endcase
  endfunction

  // Next-state logic: arbitration and latching in IDLE, wait counting in WAIT, one-cycle DONE.
  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    waitCnt_d   = waitCnt_q;
    rdata_d     = rdata_q;
    finish      = 1'b0;
    finishErr   = 1'b0;
`ifdef IO_TIMEOUT_EN
    toCnt_d     = toCnt_q;
`endif

    pick     = (m0_req && m1_req) ? ~lastGrant_q : m1_req;
    pickAddr = pick ? m1_addr : m0_addr;
    waitDone = (waitCnt_q == 4'd0) && ((region_q != R_SIE) || sie_rdy);

    case (region_q)
      R_RAM:   slaveData = ram_rdata;
      R_BOARD: slaveData = board_rdata;
      R_SIE:   slaveData = sie_rdata;
      default: slaveData = 16'h0000;
    endcase

    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          grant_d     = pick;
          lastGrant_d = pick;
          addr_d      = pickAddr[11:0];
          we_d        = pick ? m1_we : m0_we;
          wdata_d     = pick ? m1_wdata : m0_wdata;
          region_d    = decodeRegion(pickAddr[15:12]);
          waitCnt_d   = regionWs(region_d);
`ifdef IO_TIMEOUT_EN
          toCnt_d     = 8'd0;
`endif
          if (region_d == R_NONE) begin
            state_d   = S_DONE;
            rdata_d   = 16'h0000;
            finish    = 1'b1;
            finishErr = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (waitDone) begin
          state_d = S_DONE;
          rdata_d = we_q ? 16'h0000 : slaveData;
          finish  = 1'b1;
        end else begin
          if (waitCnt_q != 4'd0) begin
            waitCnt_d = waitCnt_q - 4'd1;
          end
`ifdef IO_TIMEOUT_EN
          if (toCnt_q == TO_LAST) begin
            state_d   = S_DONE;
            rdata_d   = 16'h0000;
            finish    = 1'b1;
            finishErr = 1'b1;
          end else begin
            toCnt_d = toCnt_q + 8'd1;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ramSel_d   = (state_d == S_WAIT) && (region_d == R_RAM);
    boardSel_d = (state_d == S_WAIT) && (region_d == R_BOARD);
    sieSel_d   = (state_d == S_WAIT) && (region_d == R_SIE);
    ioWe_d     = (state_d == S_WAIT) && we_d;
    rdy0_d     = finish && !grant_d;
    rdy1_d     = finish && grant_d;
    err0_d     = finish && finishErr && !grant_d;
    err1_d     = finish && finishErr && grant_d;
  end

  // State and output registers; reset abandons any transfer and favours m0 next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      region_q    <= R_NONE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= 12'h000;
      wdata_q     <= 16'h0000;
      waitCnt_q   <= 4'd0;
      rdata_q     <= 16'h0000;
      ramSel_q    <= 1'b0;
      boardSel_q  <= 1'b0;
      sieSel_q    <= 1'b0;
      ioWe_q      <= 1'b0;
      rdy0_q      <= 1'b0;
      rdy1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`ifdef IO_TIMEOUT_EN
      toCnt_q     <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      waitCnt_q   <= waitCnt_d;
      rdata_q     <= rdata_d;
      ramSel_q    <= ramSel_d;
      boardSel_q  <= boardSel_d;
      sieSel_q    <= sieSel_d;
      ioWe_q      <= ioWe_d;
      rdy0_q      <= rdy0_d;
      rdy1_q      <= rdy1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
`ifdef IO_TIMEOUT_EN
      toCnt_q     <= toCnt_d;
`endif
    end
  end

  assign m0_rdy    = rdy0_q;
  assign m0_err    = err0_q;
  assign m1_rdy    = rdy1_q;
  assign m1_err    = err1_q;
  assign rdata     = rdata_q;
  assign ram_sel   = ramSel_q;
  assign board_sel = boardSel_q;
  assign sie_sel   = sieSel_q;
  assign io_addr   = addr_q;
  assign io_we     = ioWe_q;
  assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: drives directed and random transfers into
// io_bus_arbiter and compares against a transaction-level model of the
// arbitration order, latency, select window and returned data.
module tb_io_bus_arbiter;
  localparam int RAM_WS   = 0;
  localparam int BOARD_WS = 1;
  localparam int SIE_WS   = 2;
  localparam int TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_rdy, m0_err, m1_rdy, m1_err;
  logic [15:0] rdata;
  logic        ram_sel, board_sel, sie_sel;
  logic [11:0] io_addr;
  logic        io_we;
  logic [15:0] io_wdata;
  logic [15:0] ram_rdata = '0, board_rdata = '0, sie_rdata = '0;
  logic        sie_rdy = 1'b0;

  int checks = 0;
  int failures = 0;
  int lastGrantM = 1;

  io_bus_arbiter #(
    .RAM_WS(RAM_WS), .BOARD_WS(BOARD_WS), .SIE_WS(SIE_WS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdy(m0_rdy), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdy(m1_rdy), .m1_err(m1_err),
    .rdata(rdata), .ram_sel(ram_sel), .board_sel(board_sel), .sie_sel(sie_sel),
    .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata),
    .ram_rdata(ram_rdata), .board_rdata(board_rdata), .sie_rdata(sie_rdata),
    .sie_rdy(sie_rdy)
  );

  always #5 clk = ~clk;

  // One arbitration round: model predicts winner, latency, select window and result.
  task automatic doRequest(input logic r0, input logic r1,
                           input logic [15:0] a0, input logic [15:0] a1,
                           input logic we0, input logic we1,
                           input logic [15:0] wd0, input logic [15:0] wd1,
                           input int sieD);
    int w, region, ws, waitCycles, expN, seenAt;
    logic [15:0] addr, wd, expRdata;
    logic we, expErr, badSel, badIo, badOther, rdyW, errW, rdyO, errO;
    logic [2:0] expMask;
    @(negedge clk);
    m0_req = r0; m1_req = r1;
    m0_addr = a0; m1_addr = a1; m0_we = we0; m1_we = we1;
    m0_wdata = wd0; m1_wdata = wd1; sie_rdy = 1'b0;

    if (r0 && r1) w = (lastGrantM == 1) ? 0 : 1;
    else          w = r1 ? 1 : 0;
    lastGrantM = w;
    addr = w ? a1 : a0;
    we   = w ? we1 : we0;
    wd   = w ? wd1 : wd0;
    case (addr[15:12])
      4'h2:    region = 0;
      4'h5:    region = 1;
      4'h6:    region = 2;
      default: region = 3;
    endcase
    ws = (region == 0) ? RAM_WS : (region == 1) ? BOARD_WS : SIE_WS;
    if (region == 3) begin
      expN = 1; expRdata = 16'h0000; expErr = 1'b1;
    end else begin
      waitCycles = ((region == 2) && (sieD > ws)) ? sieD + 1 : ws + 1;
      expErr = 1'b0;
      expRdata = we ? 16'h0000 :
                 (region == 0) ? ram_rdata : (region == 1) ? board_rdata : sie_rdata;
`ifdef IO_TIMEOUT_EN
      if (waitCycles > TIMEOUT) begin
        waitCycles = TIMEOUT; expErr = 1'b1; expRdata = 16'h0000;
      end
`endif
      expN = waitCycles + 1;
    end

    seenAt = 0; badSel = 0; badIo = 0; badOther = 0;
    for (int n = 1; n <= expN + 20 && seenAt == 0; n++) begin
      @(negedge clk);
      rdyW = w ? m1_rdy : m0_rdy;
      errW = w ? m1_err : m0_err;
      rdyO = w ? m0_rdy : m1_rdy;
      errO = w ? m0_err : m1_err;
      expMask = (region != 3 && n < expN) ? 3'(1 << region) : 3'b000;
      if ({sie_sel, board_sel, ram_sel} !== expMask) badSel = 1;
      if (expMask != 3'b000 && (io_addr !== addr[11:0] || io_we !== we || io_wdata !== wd))
        badIo = 1;
      if (rdyO || errO) badOther = 1;
      if (rdyW) begin
        seenAt = n;
        checks++;
        if (rdata !== expRdata) begin
          failures++;
          $display("[TB] FAIL rdata m%0d addr %h: observed %h required %h", w, addr, rdata, expRdata);
        end
        checks++;
        if (errW !== expErr) begin
          failures++;
          $display("[TB] FAIL err m%0d addr %h: observed %b required %b", w, addr, errW, expErr);
        end
        m0_req = 1'b0; m1_req = 1'b0;
      end else if (errW) begin
        badOther = 1;
      end
      if (n == 1) begin
        if (w == 0) m0_req = 1'b0; else m1_req = 1'b0;
      end
      if (region == 2 && n == 1 + sieD) sie_rdy = 1'b1;
    end

    checks++;
    if (seenAt != expN) begin
      failures++;
      $display("[TB] FAIL latency m%0d addr %h: observed cycle %0d required cycle %0d", w, addr, seenAt, expN);
    end
    checks++;
    if (badSel) begin
      failures++;
      $display("[TB] FAIL sel window addr %h: observed wrong sel pattern, required region %0d for %0d cycles", addr, region, expN - 1);
    end
    checks++;
    if (badIo) begin
      failures++;
      $display("[TB] FAIL io drive addr %h: observed io_addr/we/wdata differ, required %h/%b/%h", addr, addr[11:0], we, wd);
    end
    checks++;
    if (badOther) begin
      failures++;
      $display("[TB] FAIL stray rdy/err m%0d addr %h: observed 1 required 0", 1 - w, addr);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    sie_rdy = 1'b0;
    checks++;
    if ((m0_rdy | m1_rdy) !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rdy width: observed rdy %b%b one cycle after done, required 00", m0_rdy, m1_rdy);
    end
  endtask

  // Outputs held at zero while reset is asserted from time zero.
  task automatic test_reset();
    #1;
    checks++;
    if ({m0_rdy, m0_err, m1_rdy, m1_err, ram_sel, board_sel, sie_sel, io_we, io_addr, io_wdata, rdata} !== 52'h0) begin
      failures++;
      $display("[TB] FAIL reset outputs: observed nonzero, required all 0");
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lastGrantM = 1;
  endtask

  // Simultaneous requests alternate between masters.
  task automatic test_tie();
    board_rdata = 16'h1357;
    doRequest(1, 1, 16'h5000, 16'h5002, 0, 0, 16'h0, 16'h0, 0);
    doRequest(0, 1, 16'h5000, 16'h5002, 0, 0, 16'h0, 16'h0, 0);
    doRequest(1, 0, 16'h5004, 16'h5006, 0, 0, 16'h0, 16'h0, 0);
    doRequest(1, 1, 16'h5000, 16'h5002, 1, 0, 16'h1111, 16'h0, 0);
    doRequest(1, 0, 16'h5000, 16'h5002, 1, 0, 16'h1111, 16'h0, 0);
  endtask

  // Single RAM read with zero wait states.
  task automatic test_ram_read();
    ram_rdata = 16'hBEEF;
    doRequest(1, 0, 16'h2010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  // SIE write stalled by sie_rdy for ten cycles.
  task automatic test_sie_write();
    sie_rdata = 16'hCAFE;
    doRequest(0, 1, 16'h0, 16'h6002, 0, 1, 16'h0, 16'h00A5, 10);
  endtask

  // Unmapped read returns err with no select.
  task automatic test_unmapped();
    ram_rdata = 16'h5555;
    doRequest(1, 0, 16'h3000, 16'h0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  // SIE held not-ready: watchdog error when enabled, otherwise waits it out.
  task automatic test_sie_stall();
    sie_rdata = 16'h7E7E;
    doRequest(1, 0, 16'h6100, 16'h0, 0, 0, 16'h0, 16'h0, 40);
  endtask

  // Held request is re-granted after one idle cycle.
  task automatic test_back_to_back();
    int firstAt, secondAt;
    @(negedge clk);
    ram_rdata = 16'h1234;
    m1_req = 1'b0; m0_req = 1'b1; m0_addr = 16'h2044; m0_we = 1'b0;
    lastGrantM = 0;
    firstAt = 0; secondAt = 0;
    for (int n = 1; n <= 40 && secondAt == 0; n++) begin
      @(negedge clk);
      if (m0_rdy) begin
        if (firstAt == 0) firstAt = n; else secondAt = n;
        checks++;
        if (rdata !== 16'h1234) begin
          failures++;
          $display("[TB] FAIL b2b rdata: observed %h required 1234", rdata);
        end
      end
      if (firstAt != 0 && n == firstAt + 2) m0_req = 1'b0;
    end
    checks++;
    if (firstAt != 2 + RAM_WS) begin
      failures++;
      $display("[TB] FAIL b2b first: observed cycle %0d required %0d", firstAt, 2 + RAM_WS);
    end
    checks++;
    if (secondAt != firstAt + 3 + RAM_WS) begin
      failures++;
      $display("[TB] FAIL b2b second: observed cycle %0d required %0d", secondAt, firstAt + 3 + RAM_WS);
    end
    m0_req = 1'b0;
    @(negedge clk);
  endtask

  // Reset during a BOARD wait abandons the transfer and restores m0 priority.
  task automatic test_reset_mid();
    logic anyRdy;
    @(negedge clk);
    board_rdata = 16'h4242;
    m1_req = 1'b0; m0_req = 1'b1; m0_addr = 16'h5010; m0_we = 1'b0;
    @(negedge clk);
    m0_req = 1'b0;
    checks++;
    if (board_sel !== 1'b1) begin
      failures++;
      $display("[TB] FAIL board_sel pre-reset: observed %b required 1", board_sel);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m0_rdy, m0_err, m1_rdy, m1_err, ram_sel, board_sel, sie_sel, io_we, io_addr, io_wdata, rdata} !== 52'h0) begin
      failures++;
      $display("[TB] FAIL async reset: observed nonzero outputs, required all 0");
    end
    anyRdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      anyRdy = anyRdy | m0_rdy | m1_rdy;
    end
    reset = 1'b0;
    checks++;
    if (anyRdy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rdy during reset: observed %b required 0", anyRdy);
    end
    lastGrantM = 1;
    ram_rdata = 16'h9999;
    doRequest(1, 1, 16'h2100, 16'h5200, 0, 0, 16'h0, 16'h0, 0);
    doRequest(0, 1, 16'h2100, 16'h5200, 0, 0, 16'h0, 16'h0, 0);
  endtask

  function automatic logic [15:0] randAddr();
    logic [3:0] nibs [5];
    nibs = '{4'h2, 4'h5, 4'h6, 4'h3, 4'hA};
    randAddr = {nibs[$urandom_range(0, 4)], 12'($urandom)};
  endfunction

  // Random mix of single and contending requests across all regions.
  task automatic test_random();
    int r, sieD, loser;
    logic [15:0] a0, a1, wd0, wd1;
    logic we0, we1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(1, 3);
      a0 = randAddr(); a1 = randAddr();
      we0 = 1'($urandom); we1 = 1'($urandom);
      wd0 = 16'($urandom); wd1 = 16'($urandom);
      ram_rdata = 16'($urandom); board_rdata = 16'($urandom); sie_rdata = 16'($urandom);
      sieD = $urandom_range(0, 6);
      doRequest(r[0], r[1], a0, a1, we0, we1, wd0, wd1, sieD);
      if (r == 3) begin
        loser = 1 - lastGrantM;
        doRequest(loser == 0, loser == 1, a0, a1, we0, we1, wd0, wd1, sieD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_ram_read();
    test_sie_write();
    test_unmapped();
    test_sie_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
